nios_system_led_pio_blink: RTL and testbench

//   Parametrised Avalon-MM output PIO for board LEDs. Successor to the fixed 10-bit LED port.

---
 rtl/nios_system_led_pio_blink.sv | 104 ++++++++++
 tb/tb_nios_system_led_pio_blink.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/nios_system_led_pio_blink.sv
// Avalon-MM LED output port with a DATA register, atomic SET/CLEAR, a per-bit blink mask
// and one shared programmable blink timer. Zero-wait-state slave; readdata is combinational.
module nios_system_led_pio_blink #(
  parameter int                 DATA_W       = 10,
  parameter int                 CNT_W        = 32,
  parameter logic [DATA_W-1:0]  RESET_DATA   = '0,
  parameter logic [CNT_W-1:0]   RESET_PERIOD = CNT_W'(25000000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_BLINK  = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  // Handshake: a write is accepted on every clk edge where chipselect=1 and write_n=0;
  // there is no wait-request, so the slave is always ready. Reads have no strobe at all.
  logic              wr_en;
  logic [DATA_W-1:0] wd_data;
  logic [CNT_W-1:0]  wd_cnt;

  logic [DATA_W-1:0] data_q,   data_d;
  logic [DATA_W-1:0] blink_q,  blink_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              phase_q,  phase_d;

  assign wr_en   = chipselect & ~write_n;
  assign wd_data = writedata[DATA_W-1:0];
  assign wd_cnt  = writedata[CNT_W-1:0];

  always_comb begin
    data_d  = data_q;
    blink_d = blink_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:  data_d  = wd_data;
        ADDR_SET:   data_d  = data_q | wd_data;
        ADDR_CLEAR: data_d  = data_q & ~wd_data;
        ADDR_BLINK: blink_d = wd_data;
        default:    ;
      endcase
    end
  end

  // A PERIOD write restarts the timer at the new rate instead of finishing the old count.
  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    if (wr_en && (address == ADDR_PERIOD)) begin
      period_d = wd_cnt;
      cnt_d    = (wd_cnt == '0) ? '0 : wd_cnt - CNT_W'(1);
      phase_d  = 1'b1;
    end else if (period_q == '0) begin
      phase_d  = 1'b1;
    end else if (cnt_q == '0) begin
      cnt_d    = period_q - CNT_W'(1);
      phase_d  = ~phase_q;
    end else begin
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= RESET_DATA;
      blink_q  <= '0;
      period_q <= RESET_PERIOD;
      cnt_q    <= RESET_PERIOD;
      phase_q  <= 1'b1;
    end else begin
      data_q   <= data_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata = 32'(data_q);
      ADDR_BLINK:                      readdata = 32'(blink_q);
      ADDR_PERIOD:                     readdata = 32'(period_q);
      ADDR_STATUS:                     readdata = {31'b0, phase_q};
      default:                         readdata = '0;
    endcase
  end

  assign out_port = data_q & (~blink_q | {DATA_W{phase_q}});

endmodule

// File: tb/tb_nios_system_led_pio_blink.sv
// Bench for nios_system_led_pio_blink: driver pushes expected out_port/readdata per cycle,
// a monitor pops and compares mid-cycle; expectations come from a time-based blink model.
module tb_nios_system_led_pio_blink;

  localparam int                DATA_W   = 10;
  localparam int                CNT_W    = 32;
  localparam logic [DATA_W-1:0] RST_DATA = 10'h2A5;
  localparam logic [CNT_W-1:0]  RST_PER  = 32'd5;
  localparam int                EW       = 32 + DATA_W;

  logic              clk;
  logic              reset;
  logic [2:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] out_port;

  nios_system_led_pio_blink #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .RESET_DATA(RST_DATA), .RESET_PERIOD(RST_PER)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  end

  // reference model: phase derived from edges elapsed since the last timer restart
  logic [DATA_W-1:0] m_data, m_blink;
  logic [31:0]       m_period;
  longint            m_n;

  function automatic logic m_phase();
    if (m_period == 0 || m_n < 0) return 1'b1;
    return ((m_n / longint'(m_period)) % 2) == 0;
  endfunction

  function automatic logic [DATA_W-1:0] m_out();
    return m_data & (~m_blink | {DATA_W{m_phase()}});
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    case (a)
      3'd0, 3'd1, 3'd2: return 32'(m_data);
      3'd3:             return 32'(m_blink);
      3'd4:             return m_period;
      3'd5:             return {31'b0, m_phase()};
      default:          return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_data = RST_DATA; m_blink = '0; m_period = RST_PER; m_n = -1;
  endtask

  task automatic model_edge(input logic cs, input logic wn, input logic [2:0] a,
                            input logic [31:0] wd);
    if (cs && !wn && a == 3'd4) begin
      m_period = wd;
      m_n = 0;
    end else begin
      m_n++;
      if (cs && !wn) begin
        case (a)
          3'd0: m_data  = wd[DATA_W-1:0];
          3'd1: m_data  = m_data | wd[DATA_W-1:0];
          3'd2: m_data  = m_data & ~wd[DATA_W-1:0];
          3'd3: m_blink = wd[DATA_W-1:0];
          default: ;
        endcase
      end
    end
  endtask

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    #3;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (out_port !== e[DATA_W-1:0]) begin
        miscompares++;
        $display("FAIL out_port t=%0t got=%h exp=%h", $time, out_port, e[DATA_W-1:0]);
      end
      vectors++;
      if (readdata !== e[EW-1:DATA_W]) begin
        miscompares++;
        $display("FAIL readdata t=%0t addr=%0d got=%h exp=%h", $time, address, readdata,
                 e[EW-1:DATA_W]);
      end
    end
  end

  // driver tasks
  task automatic cycle(input logic r, input logic cs, input logic wn, input logic [2:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    reset = r; chipselect = cs; write_n = wn; address = a; writedata = wd;
    if (r) model_reset();
    exp_q.push_back({m_rd(a), m_out()});
    if (!r) model_edge(cs, wn, a, wd);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    cycle(1'b0, 1'b1, 1'b0, a, wd);
  endtask

  task automatic rd(input logic [2:0] a);
    cycle(1'b0, 1'b1, 1'b1, a, 32'd0);
  endtask

  task automatic pulse_reset();
    cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 3'd4, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 3'd5, 32'd0);
  endtask

  initial begin
    model_reset();
    pulse_reset();
    rd(3'd3); rd(3'd4);
    for (int i = 0; i < 12; i++) rd(3'd5);

    wr(3'd0, 32'h00F); wr(3'd1, 32'h300); wr(3'd2, 32'h003); rd(3'd0);

    wr(3'd4, 32'd4); wr(3'd3, 32'h001); wr(3'd0, 32'h001);
    for (int i = 0; i < 20; i++) rd(3'd5);

    wr(3'd4, 32'd0); wr(3'd3, 32'h3FF); wr(3'd0, 32'h3FF);
    for (int i = 0; i < 12; i++) rd(3'd5);

    wr(3'd4, 32'd8);
    for (int i = 0; i < 5; i++) rd(3'd5);
    wr(3'd4, 32'd3);
    for (int i = 0; i < 10; i++) rd(3'd5);

    wr(3'd5, $urandom); wr(3'd6, $urandom); wr(3'd7, $urandom);
    rd(3'd6); rd(3'd7); rd(3'd0); rd(3'd3); rd(3'd4);
    wr(3'd4, 32'd2);
    rd(3'd5); rd(3'd5); rd(3'd5);
    pulse_reset();
    rd(3'd0); rd(3'd3); rd(3'd4);

    for (int i = 0; i < 500; i++) begin
      logic [2:0]  a;
      logic [31:0] wd;
      if ($urandom_range(0, 99) < 2) begin
        pulse_reset();
      end else begin
        a  = 3'($urandom_range(0, 7));
        wd = (a == 3'd4) ? 32'($urandom_range(0, 9)) : $urandom;
        cycle(1'b0, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), a, wd);
      end
    end

    // final report
    repeat (2) @(negedge clk);
    #5;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain leftover=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
